decode_stage: RTL and testbench

- Registered RV32/RV64 base-ISA decode stage between fetch and register-read.
- Splits each instruction into its fields, generates the sign-extended immediate and format class, and flags unsupported encodings.
- Valid/ready handshake on both sides, optional two-entry skid buffer for full throughput with a registered `in_ready`, pipeline flush, and a running count of decoded legal instructions.

---
 rtl/decode_pkg.sv | 43 ++++
 rtl/decode_imm_gen.sv | 51 +++++
 rtl/decode_stage.sv | 154 +++++++++++++++
 tb/tb_decode_stage.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, format enum and decoded bundle type for the decode stage
package decode_pkg;

    // Bundle storage is sized for the widest datapath; narrower builds use the low bits.
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          f3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          f7;
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
    } decoded_t;

endpackage

// File: rtl/decode_imm_gen.sv
// rtl/decode_imm_gen.sv - combinational format classification and immediate generation
module decode_imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    // Classify the opcode; anything unlisted (or a compressed encoding) is illegal and forced to R.
    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        case (instr[6:0])
            OP_OP:                                              fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM:   fmt = FMT_I;
            OP_STORE:                                           fmt = FMT_S;
            OP_BRANCH:                                          fmt = FMT_B;
            OP_LUI, OP_AUIPC:                                   fmt = FMT_U;
            OP_JAL:                                             fmt = FMT_J;
            OP_IMM_32: begin
                if (XLEN == 64) fmt = FMT_I;
                else            illegal = 1'b1;
            end
            OP_OP_32: begin
                if (XLEN == 64) fmt = FMT_R;
                else            illegal = 1'b1;
            end
            default:                                            illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) illegal = 1'b1;
        if (illegal) fmt = FMT_R;
    end

    // Assemble the immediate per format; signed casts sign-extend from instr[31] to XLEN.
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = XLEN'($signed(instr[31:20]));
            FMT_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32/RV64 decode stage with optional two-entry skid buffer
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_f3,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [6:0]       out_f7,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic             ready_q;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_q;
    decoded_t         main_q;
    decoded_t         skid_q;
    decoded_t         dec_in;
    logic [XLEN-1:0]  imm_w;
    fmt_e             fmt_w;
    logic             illegal_w;

    decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr   (in_instr),
        .imm     (imm_w),
        .fmt     (fmt_w),
        .illegal (illegal_w)
    );

    // Build the bundle for the incoming instruction; pc zero-extends, imm sign-extends into storage.
    always_comb begin
        dec_in         = '0;
        dec_in.pc      = XLEN_MAX'(in_pc);
        dec_in.opcode  = in_instr[6:0];
        dec_in.rd      = in_instr[11:7];
        dec_in.f3      = in_instr[14:12];
        dec_in.rs1     = in_instr[19:15];
        dec_in.rs2     = in_instr[24:20];
        dec_in.f7      = in_instr[31:25];
        dec_in.imm     = XLEN_MAX'($signed(imm_w));
        dec_in.fmt     = fmt_w;
        dec_in.illegal = illegal_w;
    end

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = SKID_EN ? ready_q : (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Occupancy transitions; without the skid the ONE->FULL path is unreachable since in_ready needs out_ready.
    always_comb begin
        state_d        = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_d        = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    // State, registered in_ready and the main/skid bundle registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_d;
            ready_q <= (state_d != ST_FULL);
            if (load_main)           main_q <= dec_in;
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= dec_in;
        end
    end

    // Count legal bundles consumed downstream, including one consumed in a flush cycle; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_xfer && !main_q.illegal) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign out_pc      = main_q.pc[XLEN-1:0];
    assign out_opcode  = main_q.opcode;
    assign out_rd      = main_q.rd;
    assign out_f3      = main_q.f3;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_f7      = main_q.f7;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign dec_count   = count_q;

    if (XLEN < XLEN_MAX) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{main_q.pc[XLEN_MAX-1:XLEN], main_q.imm[XLEN_MAX-1:XLEN]};
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (RV32 skid build and RV64 single-register build)
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_ready, out_ready, out_valid, out_illegal;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [6:0]  out_opcode, out_f7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_f3, out_fmt;
    logic [15:0] dec_count;

    logic        w_flush, w_in_valid, w_in_ready, w_out_ready, w_out_valid, w_out_illegal;
    logic [31:0] w_in_instr;
    logic [63:0] w_in_pc, w_out_pc, w_out_imm;
    logic [6:0]  w_out_opcode, w_out_f7;
    logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
    logic [2:0]  w_out_f3, w_out_fmt;
    logic [15:0] w_dec_count;

    decode_stage #(.XLEN(32), .SKID_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_f3(out_f3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_f7(out_f7), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .dec_count(dec_count)
    );

    decode_stage #(.XLEN(64), .SKID_EN(1'b0), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_instr(w_in_instr), .in_pc(w_in_pc), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_pc(w_out_pc), .out_opcode(w_out_opcode), .out_rd(w_out_rd), .out_f3(w_out_f3),
        .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_f7(w_out_f7), .out_imm(w_out_imm),
        .out_fmt(w_out_fmt), .out_illegal(w_out_illegal), .dec_count(w_dec_count)
    );

    logic [99:0] act_vec32;
    assign act_vec32 = {out_pc, out_opcode, out_rd, out_f3, out_rs1, out_rs2, out_f7,
                        out_imm, out_fmt, out_illegal};

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int w_exp_cnt = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;
    item_t sbq[$];

    // Reference classification from the opcode table: returns {illegal, fmt}.
    function automatic logic [3:0] model_cls(input logic [31:0] instr, input int xlen);
        logic [6:0] op;
        op = instr[6:0];
        if (instr[1:0] != 2'b11) return 4'b1000;
        case (op)
            7'h33:                          return 4'd0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 4'd1;
            7'h23:                          return 4'd2;
            7'h63:                          return 4'd3;
            7'h37, 7'h17:                   return 4'd4;
            7'h6F:                          return 4'd5;
            7'h1B:                          return (xlen == 64) ? 4'd1 : 4'b1000;
            7'h3B:                          return (xlen == 64) ? 4'd0 : 4'b1000;
            default:                        return 4'b1000;
        endcase
    endfunction

    // Reference immediate as a signed integer value, then truncated to the datapath width.
    function automatic logic [63:0] model_imm(input logic [31:0] instr, input int xlen);
        logic [3:0] c;
        longint     v;
        logic       s;
        c = model_cls(instr, xlen);
        s = instr[31];
        v = 0;
        case (c)
            4'd1: v = longint'(instr[31:20]) - (s ? 4096 : 0);
            4'd2: v = longint'({instr[31:25], instr[11:7]}) - (s ? 4096 : 0);
            4'd3: v = 2 * longint'(instr[11:8]) + 32 * longint'(instr[30:25])
                      + 2048 * longint'(instr[7]) - (s ? 4096 : 0);
            4'd4: v = 4096 * longint'(instr[31:12]) - (s ? 64'sh1_0000_0000 : 64'sh0);
            4'd5: v = 2 * longint'(instr[30:21]) + 2048 * longint'(instr[20])
                      + 4096 * longint'(instr[19:12]) - (s ? 1048576 : 0);
            default: v = 0;
        endcase
        return (xlen == 32) ? {32'h0, v[31:0]} : v;
    endfunction

    function automatic logic [99:0] exp_vec32(input logic [31:0] instr, input logic [31:0] pc);
        logic [3:0]  c;
        logic [63:0] im;
        c  = model_cls(instr, 32);
        im = model_imm(instr, 32);
        return {pc, instr[6:0], instr[11:7], instr[14:12], instr[19:15], instr[24:20],
                instr[31:25], im[31:0], c[2:0], c[3]};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 13))
            0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h67;
            4: op = 7'h73;  5: op = 7'h0F;  6: op = 7'h23;  7: op = 7'h63;
            8: op = 7'h37;  9: op = 7'h17;  10: op = 7'h6F; 11: op = 7'h3B;
            default: op = r[6:0];
        endcase
        return {r[31:7], op};
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_instr = '0; w_in_pc = '0; w_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (act_vec32 !== 100'b0 || out_valid !== 1'b0 || dec_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vec=%h valid=%b cnt=%0d, want all 0", act_vec32, out_valid, dec_count);
        end
        checks++;
        if (in_ready !== 1'b1 || w_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b/%b, want 1/1", in_ready, w_in_ready);
        end
        checks++;
        if (w_out_valid !== 1'b0 || w_out_imm !== 64'd0 || w_out_pc !== 64'd0 || w_dec_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs64: got valid=%b imm=%h pc=%h cnt=%0d, want 0", w_out_valid, w_out_imm, w_out_pc, w_dec_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] t_instr [5] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h402081B3, 32'h123452B7};
        logic [2:0]  t_fmt   [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4};
        logic [31:0] t_imm   [5] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h0, 32'h12345000};
        logic [24:0] t_aux   [5] = '{{5'd1, 3'd0, 5'd0, 5'd31, 7'h7F}, {5'd8, 3'd2, 5'd1, 5'd2, 7'h00},
                                     {5'd29, 3'd0, 5'd0, 5'd0, 7'h7F}, {5'd3, 3'd0, 5'd1, 5'd2, 7'h20},
                                     {5'd5, 3'd5, 5'd8, 5'd3, 7'h09}};
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_instr = t_instr[k]; in_pc = 32'h1000 + 32'(4 * k); out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_fmt !== t_fmt[k] || out_imm !== t_imm[k] || out_opcode !== t_instr[k][6:0]) begin
                errors++;
                $display("FAIL directed_%0d: got valid=%b fmt=%0d imm=%h op=%h, want 1 %0d %h %h", k, out_valid, out_fmt, out_imm, out_opcode, t_fmt[k], t_imm[k], t_instr[k][6:0]);
            end
            checks++;
            if ({out_rd, out_f3, out_rs1, out_rs2, out_f7} !== t_aux[k]) begin
                errors++;
                $display("FAIL directed_fields_%0d: got %h want %h", k, {out_rd, out_f3, out_rs1, out_rs2, out_f7}, t_aux[k]);
            end
            checks++;
            if (act_vec32 !== exp_vec32(t_instr[k], 32'h1000 + 32'(4 * k))) begin
                errors++;
                $display("FAIL directed_model_%0d: got %h want %h", k, act_vec32, exp_vec32(t_instr[k], 32'h1000 + 32'(4 * k)));
            end
            @(posedge clk); #1;
            exp_cnt++;
            checks++;
            if (dec_count !== exp_cnt[15:0] || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_count_%0d: got cnt=%0d valid=%b, want %0d 0", k, dec_count, out_valid, exp_cnt);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] t_instr [4] = '{32'h00000000, 32'h0000003B, 32'h0000001B, 32'h00000091};
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_instr = t_instr[k]; in_pc = 32'h2000; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_fmt !== 3'd0 || out_imm !== 32'd0) begin
                errors++;
                $display("FAIL illegal_%0d: got valid=%b ill=%b fmt=%0d imm=%h, want 1 1 0 0", k, out_valid, out_illegal, out_fmt, out_imm);
            end
            @(posedge clk); #1;
            checks++;
            if (dec_count !== exp_cnt[15:0]) begin
                errors++;
                $display("FAIL illegal_count_%0d: got %0d want %0d", k, dec_count, exp_cnt);
            end
        end
    endtask

    // Stream driver with scoreboard: mode 0 = stall then drain, 1 = back-to-back, 2 = random handshakes.
    task automatic run_stream(input int n_items, input int mode);
        item_t       items[$];
        item_t       it;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        bit          ix, ox;
        logic [3:0]  c;
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFFC;
        for (int i = 0; i < n_items; i++) begin
            it.instr = rand_instr();
            it.pc    = base + 32'(4 * i);
            items.push_back(it);
        end
        sbq.delete();
        while (got < n_items && cyc < 40 * n_items + 50) begin
            in_valid = (sent < n_items) && (mode != 2 || $urandom_range(0, 3) != 0);
            if (sent < n_items) begin
                in_instr = items[sent].instr; in_pc = items[sent].pc;
            end else begin
                in_instr = $urandom; in_pc = $urandom;
            end
            out_ready = (mode == 0) ? (cyc >= 3) : (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            ix = in_valid && in_ready;
            ox = out_valid && out_ready;
            if (out_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL stream_spurious: got valid bundle %h, want nothing held", act_vec32);
                end else if (act_vec32 !== exp_vec32(sbq[0].instr, sbq[0].pc)) begin
                    errors++;
                    $display("FAIL stream_data cyc=%0d: got %h want %h", cyc, act_vec32, exp_vec32(sbq[0].instr, sbq[0].pc));
                end
            end
            if (mode == 0 && cyc == 2) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL skid_ready_drop: got in_ready=%b want 0 after 2 accepts", in_ready);
                end
            end
            if ((mode == 0 && cyc >= 3) || (mode == 1 && cyc >= 1 && cyc <= n_items)) begin
                checks++;
                if (ox !== 1'b1 || (mode == 1 && in_ready !== 1'b1)) begin
                    errors++;
                    $display("FAIL back_to_back cyc=%0d: got out_xfer=%b in_ready=%b want 1 1", cyc, ox, in_ready);
                end
            end
            if (ox && sbq.size() > 0) begin
                c = model_cls(sbq[0].instr, 32);
                if (!c[3]) exp_cnt++;
                void'(sbq.pop_front());
                got++;
            end
            if (ix) begin
                sbq.push_back(items[sent]);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            checks++;
            if (dec_count !== exp_cnt[15:0]) begin
                errors++;
                $display("FAIL stream_count cyc=%0d: got %0d want %0d", cyc, dec_count, exp_cnt);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != n_items || sbq.size() != 0) begin
            errors++;
            $display("FAIL stream_complete mode=%0d: got %0d delivered, %0d pending, want %0d, 0", mode, got, sbq.size(), n_items);
        end
    endtask

    task automatic test_skid_stall();
        run_stream(4, 0);
    endtask

    task automatic test_back_to_back();
        run_stream(16, 1);
    endtask

    task automatic test_random_stream();
        run_stream(300, 2);
    endtask

    task automatic test_xlen64();
        logic [31:0] t_instr [5] = '{32'h0000003B, 32'h800002B7, 32'hFFF0009B, 32'hFE000EE3, 32'h0000007F};
        logic [63:0] t_imm   [5] = '{64'h0, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'h0};
        logic [3:0]  t_cls   [5] = '{4'd0, 4'd4, 4'd1, 4'd3, 4'b1000};
        logic [3:0]  c;
        for (int k = 0; k < 5; k++) begin
            w_in_valid = 1'b1; w_in_instr = t_instr[k]; w_in_pc = 64'hFFFF_0000_0000_0000 + 64'(8 * k); w_out_ready = 1'b0;
            #1;
            checks++;
            if (w_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL x64_ready_empty_%0d: got %b want 1", k, w_in_ready);
            end
            @(posedge clk); #1;
            w_in_valid = 1'b0;
            c = model_cls(t_instr[k], 64);
            checks++;
            if (w_out_valid !== 1'b1 || w_out_imm !== t_imm[k] || {w_out_illegal, w_out_fmt} !== t_cls[k]
                || w_out_imm !== model_imm(t_instr[k], 64) || {w_out_illegal, w_out_fmt} !== c
                || w_out_pc !== 64'hFFFF_0000_0000_0000 + 64'(8 * k)) begin
                errors++;
                $display("FAIL x64_decode_%0d: got valid=%b imm=%h ill/fmt=%h pc=%h, want 1 %h %h", k, w_out_valid, w_out_imm, {w_out_illegal, w_out_fmt}, w_out_pc, t_imm[k], t_cls[k]);
            end
            checks++;
            if (w_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL x64_ready_stall_%0d: got %b want 0", k, w_in_ready);
            end
            w_out_ready = 1'b1;
            #1;
            checks++;
            if (w_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL x64_ready_comb_%0d: got %b want 1", k, w_in_ready);
            end
            @(posedge clk); #1;
            w_out_ready = 1'b0;
            if (!c[3]) w_exp_cnt++;
            checks++;
            if (w_dec_count !== w_exp_cnt[15:0] || w_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL x64_count_%0d: got cnt=%0d valid=%b want %0d 0", k, w_dec_count, w_out_valid, w_exp_cnt);
            end
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h3000; out_ready = 1'b0;
        @(posedge clk); #1;
        in_instr = 32'h00200113; in_pc = 32'h3004;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_fill: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        flush = 1'b1; in_instr = 32'h00300193; in_pc = 32'h3008;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || dec_count !== exp_cnt[15:0]) begin
                errors++;
                $display("FAIL flush_nothing_%0d: got valid=%b cnt=%0d want 0 %0d", i, out_valid, dec_count, exp_cnt);
            end
        end
        in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 32'h3010;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_cnt++;
        checks++;
        if (out_valid !== 1'b0 || dec_count !== exp_cnt[15:0]) begin
            errors++;
            $display("FAIL flush_with_out_xfer: got valid=%b cnt=%0d want 0 %0d", out_valid, dec_count, exp_cnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; in_instr = 32'h00700393; in_pc = 32'h4000; out_ready = 1'b0;
        @(posedge clk); #1;
        in_instr = 32'h00800413; in_pc = 32'h4004;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (act_vec32 !== 100'b0 || out_valid !== 1'b0 || dec_count !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got vec=%h valid=%b cnt=%0d rdy=%b want 0 0 0 1", act_vec32, out_valid, dec_count, in_ready);
        end
        checks++;
        if (w_dec_count !== 16'd0 || w_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid64: got cnt=%0d valid=%b want 0 0", w_dec_count, w_out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        w_exp_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || dec_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_mid_nothing_%0d: got valid=%b cnt=%0d want 0 0", i, out_valid, dec_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_skid_stall();
        test_back_to_back();
        test_random_stream();
        test_xlen64();
        test_flush();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
